// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared router definitions: default FIFO geometry, the
//                output-port index enum and the one-hot pointer type.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

    // Default flit width and FIFO depth (depth must be a power of two, >= 2)
    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_DEFAULT_DEPTH      = 4;
    localparam int c_NUM_PORTS          = 5;

    // Index of each downstream port in a grant vector
    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_W = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // One-hot slot pointer for a FIFO of default depth
    typedef logic [c_DEFAULT_DEPTH-1:0] ptr_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr
//  Description : One-hot rotating pointer. Resets to bit 0 and rotates left
//                by one position (wrapping) on every cycle that en is high.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ptr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] c_PTR_RESET = {{(WIDTH-1){1'b0}}, 1'b1};

    // Rotate the one-hot pointer left when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= c_PTR_RESET;
        end else if (en) begin
            ptr <= {ptr[WIDTH-2:0], ptr[WIDTH-1]};
        end
    end

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_in.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_in
//  Description : Router input FIFO with a CTS/DRTS handshake towards the
//                upstream link and five one-hot grant inputs from the
//                downstream arbiters. Data_out is combinational from storage.
//                Optional macro FIFO_ERR_EN adds a sticky protocol-error
//                output 'err' (multiple grants, or a grant while empty).
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_in
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = c_DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] Data_out
`ifdef FIFO_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_cts;
    logic                   r_rst_done;
    logic [DEPTH-1:0]       w_rd_ptr;
    logic [DEPTH-1:0]       w_wr_ptr;
    logic [c_NUM_PORTS-1:0] w_grants;
    logic                   w_grant_any;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_cts_next;
    logic                   w_write;
    logic                   w_read;

    assign w_grants[PORT_N] = read_en_N;
    assign w_grants[PORT_E] = read_en_E;
    assign w_grants[PORT_W] = read_en_W;
    assign w_grants[PORT_S] = read_en_S;
    assign w_grants[PORT_L] = read_en_L;
    assign w_grant_any      = |w_grants;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // CTS is a one-cycle pulse; r_rst_done holds it off on the first edge
    // after reset release so acceptance starts no earlier than the second.
    assign w_cts_next = DRTS & ~r_cts & ~w_full & r_rst_done;
    assign w_write    = w_cts_next;
    assign w_read     = w_grant_any & ~w_empty;

    assign CTS   = r_cts;
    assign empty = w_empty;

    // Registered clear-to-send and post-reset qualifier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cts      <= 1'b0;
            r_rst_done <= 1'b0;
        end else begin
            r_cts      <= w_cts_next;
            r_rst_done <= 1'b1;
        end
    end

    // Occupancy: simultaneous read and write leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_write && !w_read) begin
            r_count <= r_count + c_ONE;
        end else if (w_read && !w_write) begin
            r_count <= r_count - c_ONE;
        end
    end

    fifo_ptr #(.WIDTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (w_write),
        .ptr (w_wr_ptr)
    );

    fifo_ptr #(.WIDTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (w_read),
        .ptr (w_rd_ptr)
    );

    // Flit storage, written at the one-hot write pointer (no reset needed)
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        always_ff @(posedge clk) begin
            if (w_write && w_wr_ptr[g]) begin
                r_mem[g] <= RX;
            end
        end
    end

    // Zero-latency read mux selected by the one-hot read pointer
    always_comb begin
        Data_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_rd_ptr[i]) begin
                Data_out = r_mem[i];
            end
        end
    end

`ifdef FIFO_ERR_EN
    logic w_multi_grant;
    assign w_multi_grant = ($countones(w_grants) > 1);

    // Sticky protocol error: conflicting grants or a grant on an empty FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (w_multi_grant || (w_grant_any && w_empty)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule : fifo_in
`default_nettype wire
